// File: rtl/vec_mem_sequencer_if.sv
// Bus bundle for the vector/fetch memory sequencer: fetch, vector and memory port signals.
interface vec_mem_sequencer_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 16
);
    localparam int unsigned VEC_W = LANES * DATA_W;

    // Instruction fetch side
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_grant;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;

    // Vector load/store side
    logic              vec_req;
    logic              vec_wr;
    logic [ADDR_W-1:0] vec_base;
    logic [VEC_W-1:0]  vec_wdata;
    logic              vec_busy;
    logic              vec_done;
    logic [VEC_W-1:0]  vec_rdata;

    // Memory port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Requesters and memory model
    modport master (
        output fetch_req, fetch_addr, vec_req, vec_wr, vec_base, vec_wdata, mem_rdata,
        input  fetch_grant, fetch_valid, fetch_data, vec_busy, vec_done, vec_rdata,
        input  mem_addr, mem_rd, mem_wr, mem_wdata
    );

    // Sequencer
    modport slave (
        input  fetch_req, fetch_addr, vec_req, vec_wr, vec_base, vec_wdata, mem_rdata,
        output fetch_grant, fetch_valid, fetch_data, vec_busy, vec_done, vec_rdata,
        output mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Single-port memory sequencer: arbitrates instruction fetch against 16-beat vector load/store bursts.
module vec_mem_sequencer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANES  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vec_mem_sequencer_if.slave   bus
);
    localparam int unsigned VEC_W = LANES * DATA_W;
    localparam int unsigned CNT_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

    typedef enum logic [2:0] {
        IDLE, F_ISSUE, F_DATA, VLD_RUN, VLD_DRAIN, VST_RUN, DONE
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc, cap_idx;
    logic              cap_en;
    logic [ADDR_W-1:0] base_q, base_n;
    logic [VEC_W-1:0]  wdata_q, wdata_n;
    logic [VEC_W-1:0]  rdata_q, rdata_n;
    logic [DATA_W-1:0] fdata_q, fdata_n;
    logic [DATA_W-1:0] wlane;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wd_q, wd_n;
    logic              rd_q, rd_n, wr_q, wr_n;
    logic              grant_q, grant_n, valid_q, valid_n;
    logic              busy_q, busy_n, done_q, done_n;

    // State, latched request data and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fdata_q <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            grant_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            base_q  <= base_n;
            wdata_q <= wdata_n;
            rdata_q <= rdata_n;
            fdata_q <= fdata_n;
            addr_q  <= addr_n;
            wd_q    <= wd_n;
            rd_q    <= rd_n;
            wr_q    <= wr_n;
            grant_q <= grant_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        base_n  = base_q;
        wdata_n = wdata_q;
        rdata_n = rdata_q;
        fdata_n = fdata_q;
        addr_n  = addr_q;
        wd_n    = wd_q;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        grant_n = 1'b0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        cap_en  = 1'b0;
        cap_idx = '0;
        cnt_inc = cnt + CNT_W'(1);

        // Store lane for the next beat
        wlane = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CNT_W'(i) == cnt_inc) wlane = wdata_q[i*DATA_W +: DATA_W];
        end

        case (state)
            IDLE: begin
                if (bus.vec_req) begin
                    busy_n = 1'b1;
                    cnt_n  = '0;
                    base_n = bus.vec_base;
                    addr_n = bus.vec_base;
                    if (bus.vec_wr) begin
                        state_n = VST_RUN;
                        wdata_n = bus.vec_wdata;
                        wr_n    = 1'b1;
                        wd_n    = bus.vec_wdata[DATA_W-1:0];
                    end else begin
                        state_n = VLD_RUN;
                        rd_n    = 1'b1;
                    end
                end else if (bus.fetch_req) begin
                    state_n = F_ISSUE;
                    rd_n    = 1'b1;
                    addr_n  = bus.fetch_addr;
                    grant_n = 1'b1;
                end
            end
            F_ISSUE: begin
                state_n = F_DATA;
                valid_n = 1'b1;
            end
            F_DATA: begin
                state_n = IDLE;
                fdata_n = bus.mem_rdata;
            end
            VLD_RUN: begin
                busy_n = 1'b1;
                // Data for the previous beat arrives one cycle after its strobe
                if (cnt != '0) begin
                    cap_en  = 1'b1;
                    cap_idx = cnt - CNT_W'(1);
                end
                if (cnt == LAST) begin
                    state_n = VLD_DRAIN;
                end else begin
                    cnt_n  = cnt_inc;
                    rd_n   = 1'b1;
                    addr_n = base_q + ADDR_W'(cnt_inc);
                end
            end
            VLD_DRAIN: begin
                busy_n  = 1'b1;
                cap_en  = 1'b1;
                cap_idx = LAST;
                state_n = DONE;
                done_n  = 1'b1;
            end
            VST_RUN: begin
                busy_n = 1'b1;
                if (cnt == LAST) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n  = cnt_inc;
                    wr_n   = 1'b1;
                    addr_n = base_q + ADDR_W'(cnt_inc);
                    wd_n   = wlane;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Progressive lane capture for loads
        if (cap_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (CNT_W'(i) == cap_idx) rdata_n[i*DATA_W +: DATA_W] = bus.mem_rdata;
            end
        end
    end

    // fetch_data shows the returning word in F_DATA so it lines up with fetch_valid, then holds
    assign bus.fetch_data  = (state == F_DATA) ? bus.mem_rdata : fdata_q;
    assign bus.fetch_grant = grant_q;
    assign bus.fetch_valid = valid_q;
    assign bus.vec_busy    = busy_q;
    assign bus.vec_done    = done_q;
    assign bus.vec_rdata   = rdata_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_rd      = rd_q;
    assign bus.mem_wr      = wr_q;
    assign bus.mem_wdata   = wd_q;
endmodule
